irq_arbiter: RTL and testbench
==============================

# irq_arbiter

Multi-source interrupt arbiter for the dashcam peripheral subsystem. It latches event pulses from up to NUM_SRC sources (DMA done, frame done, sensor error, …), applies an enable mask, and presents one interrupt at a time to the CPU with a source ID. It waits for an explicit acknowledge, then enforces a programmable holdoff so that bursty sources cannot storm the core. It replaces per-source single-bit pending latches at the CPU interrupt input.

## Interface
- NUM_SRC, 4, number of event sources (2..16); index 0 is highest priority.
- HOLDOFF_W, 8, width of the holdoff counter.
- ID_W, $clog2(NUM_SRC), width of irq_id (derived, not overridden).

- clk  in  1  single clock; all logic rises on posedge clk.
- rst  in  1  reset, synchronous, active-high.
- src_evt  in  NUM_SRC  per-source single-cycle event pulse; a level held N cycles counts as N events.
- mask_wr  in  1  write strobe for mask.
- mask_wdata  in  NUM_SRC  new mask value (1 = enabled).
- holdoff_cycles  in  HOLDOFF_W  quiet cycles after each ack; sampled at ack.
- ack  in  1  CPU acknowledge of the currently presented irq_id.
- irq  out  1  interrupt request, registered.
- irq_id  out  ID_W  source being presented; valid while irq=1, holds last value otherwise.
- pending  out  NUM_SRC  latched, unacknowledged events (independent of mask).
- mask  out  NUM_SRC  current enable mask.
- overrun  out  NUM_SRC  sticky: an event arrived while that source was already pending.

## Operation
- Reset values: irq=0, irq_id=0, pending=0, overrun=0, mask=all ones, state=IDLE, holdoff counter=0.
- pending[i] is set by src_evt[i]; cleared only by an accepted ack with irq_id==i. If set and clear coincide, set wins (pending stays 1, overrun[i] clears).
- overrun[i] is set when src_evt[i]=1 while pending[i]=1 (outside the set-wins case above); cleared together with pending[i] on ack.
- mask is updated on mask_wr, visible the following cycle. Masked sources still latch pending/overrun.
- Selection uses fixed priority: the lowest index i with pending[i]&mask[i].
- FSM states:
  - IDLE: if any pending&mask, register irq_id=selected, irq<=1 and go to ASSERT. Otherwise stay.
  - ASSERT: irq=1 and irq_id frozen. On ack: clear pending/overrun[irq_id] and set irq<=0. If holdoff_cycles==0, go to IDLE; else load the counter with holdoff_cycles and go to HOLDOFF. If mask[irq_id] reads 0 and there is no ack: retract, so irq<=0, pending is kept, and the FSM goes to IDLE. Ack wins over retraction in the same cycle.
  - HOLDOFF: irq=0; the counter decrements each cycle; when the counter==1, go to IDLE. New events keep latching.
- ack outside ASSERT is ignored, with no side effects.
- A higher-priority event arriving during ASSERT does not preempt; it is served after ack plus holdoff.

## Timing
- src_evt[i] high in cycle t: pending[i]=1 at t+1. From IDLE, irq=1 with irq_id=i at t+2 (2-cycle latency).
- ack high in cycle t with irq=1: irq=0 and pending cleared at t+1.
- Holdoff H>0: the FSM is in HOLDOFF for exactly H cycles. The earliest re-assertion is irq=1 at t+H+2. With H=0, the earliest re-assertion is at t+2 (one cycle irq=0 minimum).
- Mask retraction: mask_wr clears the bit in cycle t, so mask=0 at t+1 and irq=0 at t+2.
- rst asserted in any cycle, including mid-ASSERT or HOLDOFF: all state returns to reset values at the next edge. Events in the reset cycle are dropped.

## Structure
- Package irq_pkg: state enum typedef irq_state_e {IDLE, ASSERT, HOLDOFF}, and constant IRQ_MAX_SRC=16.
- Sub-module irq_prio_enc: combinational, parameterised by NUM_SRC. It takes a request vector and returns valid plus the lowest-index ID. It is instantiated once and reused by the bench as a reference model.
- Top module holds the pending/overrun/mask registers, the FSM and the holdoff counter.

## Test plan
- Single event: src_evt[2] pulse at cycle 10 → pending=4'b0100 at 11, irq=1/irq_id=2 at 12. Ack at 15 → irq=0, pending=0 at 16.
- Priority and no preemption: src_evt=4'b1000 at 10, then 4'b0001 at 13. Expect irq_id=3 presented first. Ack at 14 with H=3 → irq_id=0 presented at 19.
- Holdoff boundary: H=0, two pending sources, ack at t → irq low at t+1 and high at t+2 with the next ID. Repeat with H=255 → gap of exactly 255 HOLDOFF cycles.
- Mask: mask=4'b1110 with src_evt[0] → pending[0]=1, irq stays 0. Then mask_wr 4'b1111 → irq_id=0 two cycles later. Clearing mask[0] during ASSERT → retraction with pending kept.
- Overrun and simultaneity: two src_evt[1] pulses before ack → overrun[1]=1. src_evt[1] coincident with ack of ID 1 → pending[1]=1, overrun[1]=0, irq re-asserts after holdoff.
- Reset mid-operation: rst during ASSERT with pending=4'b0110 → next cycle irq=0, pending=0, overrun=0, mask=4'b1111. Ack after reset produces no change.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and limits for the interrupt arbiter.
// Purely declarative; no logic, no latency, no flow control.
package irq_pkg;
    localparam int IRQ_MAX_SRC = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } irq_state_e;
endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index of req wins.
// Combinational, zero latency; no flow control.
module irq_prio_enc #(
    parameter  int NUM_SRC = 4,
    localparam int ID_W    = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               vld,
    output logic [ID_W-1:0]    id
);
    // Scan from the top down so the last hit is the lowest index.
    always_comb begin
        vld = 1'b0;
        id  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                vld = 1'b1;
                id  = ID_W'(i);
            end
        end
    end
endmodule

// File: rtl/irq_arbiter.sv
// Latches source events, presents one masked interrupt at a time, holds off after ack.
// Event-to-irq 2 cycles; irq stays up until ack or mask retraction, then optional quiet gap.
module irq_arbiter
    import irq_pkg::*;
#(
    parameter  int NUM_SRC   = 4,
    parameter  int HOLDOFF_W = 8,
    localparam int ID_W      = $clog2(NUM_SRC)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   src_evt,
    input  logic                 mask_wr,
    input  logic [NUM_SRC-1:0]   mask_wdata,
    input  logic [HOLDOFF_W-1:0] holdoff_cycles,
    input  logic                 ack,
    output logic                 irq,
    output logic [ID_W-1:0]      irq_id,
    output logic [NUM_SRC-1:0]   pending,
    output logic [NUM_SRC-1:0]   mask,
    output logic [NUM_SRC-1:0]   overrun
);
    irq_state_e           state;
    logic [HOLDOFF_W-1:0] cnt;
    logic                 sel_vld;
    logic [ID_W-1:0]      sel_id;
    logic                 ack_ok;
    logic [NUM_SRC-1:0]   clr;

    irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
        .req (pending & mask),
        .vld (sel_vld),
        .id  (sel_id)
    );

    assign ack_ok = (state == ASSERT) && ack;
    assign clr    = ack_ok ? (NUM_SRC'(1) << irq_id) : '0;

    // A new event coinciding with its own ack re-arms pending but starts overrun afresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            overrun <= '0;
            mask    <= '1;
        end else begin
            pending <= src_evt | (pending & ~clr);
            overrun <= (overrun | (src_evt & pending)) & ~clr;
            if (mask_wr) begin
                mask <= mask_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            irq    <= 1'b0;
            irq_id <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        irq_id <= sel_id;
                        irq    <= 1'b1;
                        state  <= ASSERT;
                    end
                end
                ASSERT: begin
                    if (ack) begin
                        irq <= 1'b0;
                        if (holdoff_cycles == '0) begin
                            state <= IDLE;
                        end else begin
                            cnt   <= holdoff_cycles;
                            state <= HOLDOFF;
                        end
                    end else if (!mask[irq_id]) begin
                        irq   <= 1'b0;
                        state <= IDLE;
                    end
                end
                HOLDOFF: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == HOLDOFF_W'(1)) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    irq   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter with hand-computed expectations per scenario.
module tb_irq_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] src_evt;
    logic       mask_wr;
    logic [3:0] mask_wdata;
    logic [7:0] holdoff_cycles;
    logic       ack;
    logic       irq;
    logic [1:0] irq_id;
    logic [3:0] pending;
    logic [3:0] mask;
    logic [3:0] overrun;
    logic       ref_vld;
    logic [1:0] ref_id;

    int checks = 0;
    int errors = 0;

    irq_arbiter #(.NUM_SRC(4), .HOLDOFF_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .src_evt        (src_evt),
        .mask_wr        (mask_wr),
        .mask_wdata     (mask_wdata),
        .holdoff_cycles (holdoff_cycles),
        .ack            (ack),
        .irq            (irq),
        .irq_id         (irq_id),
        .pending        (pending),
        .mask           (mask),
        .overrun        (overrun)
    );

    irq_prio_enc #(.NUM_SRC(4)) u_ref (
        .req (pending & mask),
        .vld (ref_vld),
        .id  (ref_id)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; src_evt = '0; mask_wr = 1'b0; mask_wdata = '0;
        holdoff_cycles = '0; ack = 1'b0;
        step(); step();
        rst = 1'b0;
        checks++;
        if (irq !== 1'b0 || irq_id !== 2'd0 || pending !== 4'b0000 || overrun !== 4'b0000 || mask !== 4'b1111) begin
            errors++;
            $display("FAIL reset: irq=%b id=%0d pend=%b ovr=%b mask=%b, want 0 0 0000 0000 1111",
                     irq, irq_id, pending, overrun, mask);
        end
    endtask

    task automatic test_single();
        holdoff_cycles = 8'd0;
        src_evt = 4'b0100;
        step();
        src_evt = '0;
        checks++;
        if (pending !== 4'b0100 || irq !== 1'b0) begin
            errors++;
            $display("FAIL single_latch: pend=%b irq=%b, want 0100 0", pending, irq);
        end
        step();
        checks++;
        if (irq !== 1'b1 || irq_id !== 2'd2) begin
            errors++;
            $display("FAIL single_assert: irq=%b id=%0d, want 1 2", irq, irq_id);
        end
        step(); step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++;
        if (irq !== 1'b0 || pending !== 4'b0000) begin
            errors++;
            $display("FAIL single_ack: irq=%b pend=%b, want 0 0000", irq, pending);
        end
        step(); step();
        checks++;
        if (irq !== 1'b0 || irq_id !== 2'd2) begin
            errors++;
            $display("FAIL single_quiet: irq=%b id=%0d, want 0 2", irq, irq_id);
        end
    endtask

    task automatic test_priority();
        src_evt = 4'b1000;           // cycle 10
        step();
        src_evt = '0;
        step();                      // cycle 12
        checks++;
        if (irq !== 1'b1 || irq_id !== 2'd3) begin
            errors++;
            $display("FAIL prio_first: irq=%b id=%0d, want 1 3", irq, irq_id);
        end
        src_evt = 4'b0001;           // cycle 13
        step();
        src_evt = '0;                // cycle 14
        checks++;
        if (irq !== 1'b1 || irq_id !== 2'd3 || pending !== 4'b1001) begin
            errors++;
            $display("FAIL prio_no_preempt: irq=%b id=%0d pend=%b, want 1 3 1001", irq, irq_id, pending);
        end
        checks++;
        if (ref_vld !== 1'b1 || ref_id !== 2'd0) begin
            errors++;
            $display("FAIL prio_encoder: vld=%b id=%0d, want 1 0", ref_vld, ref_id);
        end
        ack = 1'b1; holdoff_cycles = 8'd3;
        step();                      // cycle 15
        ack = 1'b0;
        checks++;
        if (irq !== 1'b0 || pending !== 4'b0001) begin
            errors++;
            $display("FAIL prio_ack: irq=%b pend=%b, want 0 0001", irq, pending);
        end
        for (int c = 16; c <= 18; c++) begin
            step();
            checks++;
            if (irq !== 1'b0) begin
                errors++;
                $display("FAIL prio_holdoff_c%0d: irq=%b, want 0", c, irq);
            end
        end
        step();                      // cycle 19
        checks++;
        if (irq !== 1'b1 || irq_id !== 2'd0) begin
            errors++;
            $display("FAIL prio_second: irq=%b id=%0d, want 1 0", irq, irq_id);
        end
        ack = 1'b1; holdoff_cycles = 8'd0;
        step();
        ack = 1'b0;
        step();
    endtask

    task automatic test_holdoff();
        int n;
        holdoff_cycles = 8'd0;
        src_evt = 4'b0011;
        step();
        src_evt = '0;
        step();
        checks++;
        if (irq !== 1'b1 || irq_id !== 2'd0) begin
            errors++;
            $display("FAIL h0_first: irq=%b id=%0d, want 1 0", irq, irq_id);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL h0_gap: irq=%b, want 0", irq);
        end
        step();
        checks++;
        if (irq !== 1'b1 || irq_id !== 2'd1) begin
            errors++;
            $display("FAIL h0_next: irq=%b id=%0d, want 1 1", irq, irq_id);
        end
        ack = 1'b1; holdoff_cycles = 8'd255; src_evt = 4'b1000;
        step();
        ack = 1'b0; src_evt = '0;
        n = 0;
        while (irq !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        checks++;
        if (n !== 256 || irq_id !== 2'd3) begin
            errors++;
            $display("FAIL h255_gap: cycles_to_irq=%0d id=%0d, want 256 3", n, irq_id);
        end
        ack = 1'b1; holdoff_cycles = 8'd0;
        step();
        ack = 1'b0;
        step();
    endtask

    task automatic test_mask();
        mask_wr = 1'b1; mask_wdata = 4'b1110;
        step();
        mask_wr = 1'b0;
        checks++;
        if (mask !== 4'b1110) begin
            errors++;
            $display("FAIL mask_write: mask=%b, want 1110", mask);
        end
        src_evt = 4'b0001;
        step();
        src_evt = '0;
        step(); step();
        checks++;
        if (pending !== 4'b0001 || irq !== 1'b0) begin
            errors++;
            $display("FAIL mask_blocked: pend=%b irq=%b, want 0001 0", pending, irq);
        end
        mask_wr = 1'b1; mask_wdata = 4'b1111;
        step();
        mask_wr = 1'b0;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL mask_enable_early: irq=%b, want 0", irq);
        end
        step();
        checks++;
        if (irq !== 1'b1 || irq_id !== 2'd0) begin
            errors++;
            $display("FAIL mask_enable: irq=%b id=%0d, want 1 0", irq, irq_id);
        end
        mask_wr = 1'b1; mask_wdata = 4'b1110;
        step();
        mask_wr = 1'b0;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL retract_early: irq=%b, want 1", irq);
        end
        step();
        checks++;
        if (irq !== 1'b0 || pending !== 4'b0001) begin
            errors++;
            $display("FAIL retract: irq=%b pend=%b, want 0 0001", irq, pending);
        end
        mask_wr = 1'b1; mask_wdata = 4'b1111;
        step();
        mask_wr = 1'b0;
        step();
        ack = 1'b1; holdoff_cycles = 8'd0;
        step();
        ack = 1'b0;
        step();
        checks++;
        if (pending !== 4'b0000 || irq !== 1'b0) begin
            errors++;
            $display("FAIL mask_cleanup: pend=%b irq=%b, want 0000 0", pending, irq);
        end
    endtask

    task automatic test_overrun();
        src_evt = 4'b0010;
        step();
        step();
        src_evt = '0;
        checks++;
        if (overrun !== 4'b0010 || irq !== 1'b1 || irq_id !== 2'd1) begin
            errors++;
            $display("FAIL overrun_set: ovr=%b irq=%b id=%0d, want 0010 1 1", overrun, irq, irq_id);
        end
        ack = 1'b1; holdoff_cycles = 8'd2; src_evt = 4'b0010;
        step();
        ack = 1'b0; src_evt = '0;
        checks++;
        if (pending !== 4'b0010 || overrun !== 4'b0000 || irq !== 1'b0) begin
            errors++;
            $display("FAIL set_wins: pend=%b ovr=%b irq=%b, want 0010 0000 0", pending, overrun, irq);
        end
        step(); step();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL set_wins_holdoff: irq=%b, want 0", irq);
        end
        step();
        checks++;
        if (irq !== 1'b1 || irq_id !== 2'd1) begin
            errors++;
            $display("FAIL set_wins_reassert: irq=%b id=%0d, want 1 1", irq, irq_id);
        end
        ack = 1'b1; holdoff_cycles = 8'd0;
        step();
        ack = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        src_evt = 4'b0110; mask_wr = 1'b1; mask_wdata = 4'b0111;
        step();
        src_evt = '0; mask_wr = 1'b0;
        step();
        checks++;
        if (irq !== 1'b1 || irq_id !== 2'd1 || pending !== 4'b0110) begin
            errors++;
            $display("FAIL rst_setup: irq=%b id=%0d pend=%b, want 1 1 0110", irq, irq_id, pending);
        end
        rst = 1'b1; src_evt = 4'b1000;
        step();
        rst = 1'b0; src_evt = '0;
        checks++;
        if (irq !== 1'b0 || irq_id !== 2'd0 || pending !== 4'b0000 || overrun !== 4'b0000 || mask !== 4'b1111) begin
            errors++;
            $display("FAIL rst_mid: irq=%b id=%0d pend=%b ovr=%b mask=%b, want 0 0 0000 0000 1111",
                     irq, irq_id, pending, overrun, mask);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
        checks++;
        if (irq !== 1'b0 || pending !== 4'b0000 || overrun !== 4'b0000) begin
            errors++;
            $display("FAIL rst_ack_ignored: irq=%b pend=%b ovr=%b, want 0 0000 0000", irq, pending, overrun);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_holdoff();
        test_mask();
        test_overrun();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
